// File: rtl/sad_matcher_pkg.sv
// ----------------------------------------------------------------------------
// astro_pkg : shared constants and types for the SAD template matcher.
//   WIN_DIM   - window/template edge length in pixels
//   POS_MAX   - largest window column/row index in a frame
//   SAD_W     - width of a window SAD value
//   WIN_COUNT - number of windows in one frame ((POS_MAX+1)^2)
//   window_t  - one 16x16 patch of 8-bit pixels, [row][col][bit]
//   row_t     - one 16-pixel row of a patch
//   state_e   - matcher FSM states
//   pos_t     - window position carried down the pipeline
// ----------------------------------------------------------------------------
package astro_pkg;

  localparam int WIN_DIM   = 16;
  localparam int POS_MAX   = 64;
  localparam int SAD_W     = 16;
  localparam int WIN_COUNT = 4225;

  typedef logic [WIN_DIM-1:0][WIN_DIM-1:0][7:0] window_t;
  typedef logic [WIN_DIM-1:0][7:0]              row_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  typedef struct packed {
    logic [6:0] x;
    logic [6:0] y;
  } pos_t;

endpackage

// File: rtl/sad_matcher_if.sv
// ----------------------------------------------------------------------------
// sad_matcher_if : window stream between the window handler and the matcher.
//   window_data  - candidate window (handler -> matcher)
//   window_ready - window_data valid this cycle (handler -> matcher)
//   frame_done   - handler finished the frame (handler -> matcher)
//   receive      - window accepted this cycle (matcher -> handler)
// master = window handler side, slave = matcher side.
// ----------------------------------------------------------------------------
interface sad_matcher_if;
  import astro_pkg::*;

  window_t window_data;
  logic    window_ready;
  logic    frame_done;
  logic    receive;

  modport master (
    output window_data,
    output window_ready,
    output frame_done,
    input  receive
  );

  modport slave (
    input  window_data,
    input  window_ready,
    input  frame_done,
    output receive
  );
endinterface

// File: rtl/sad_matcher_row_unit.sv
// ----------------------------------------------------------------------------
// sad_row_unit : one template row against one window row.
//   clk        - rising-edge clock
//   i_tmpl_row - 16 template pixels
//   i_win_row  - 16 window pixels
//   o_row_sum  - registered 12-bit sum of absolute differences
// Stage 1 registers the 16 absolute differences, stage 2 registers their sum.
// Datapath only: validity is tracked by the parent, so no reset is needed.
// ----------------------------------------------------------------------------
module sad_row_unit
  import astro_pkg::*;
(
  input  logic        clk,
  input  row_t        i_tmpl_row,
  input  row_t        i_win_row,
  output logic [11:0] o_row_sum
);

  row_t        w_absdiff;
  row_t        r_absdiff;
  logic [11:0] w_sum;
  logic [11:0] r_row_sum;

  for (genvar gi = 0; gi < WIN_DIM; gi++) begin : g_pix
    assign w_absdiff[gi] = (i_tmpl_row[gi] > i_win_row[gi]) ?
                           (i_tmpl_row[gi] - i_win_row[gi]) :
                           (i_win_row[gi] - i_tmpl_row[gi]);
  end

  // 16 x 255 = 4080 fits in 12 bits without overflow
  always_comb begin
    w_sum = '0;
    for (int i = 0; i < WIN_DIM; i++) begin
      w_sum = w_sum + 12'(r_absdiff[i]);
    end
  end

  always_ff @(posedge clk) begin
    r_absdiff <= w_absdiff;
    r_row_sum <= w_sum;
  end

  assign o_row_sum = r_row_sum;

endmodule

// File: rtl/sad_matcher.sv
// ----------------------------------------------------------------------------
// sad_matcher : finds the minimum-SAD window of a frame against a template.
//   clk, rst      - clock, synchronous active-high reset
//   template_data - reference patch, latched by template_load while idle
//   start         - begin a new frame search (any state)
//   win           - window stream (sad_matcher_if.slave)
//   busy          - FSM not idle
//   result_valid  - one-cycle pulse when best_* are final
//   best_sad/x/y  - minimum SAD and its window position
//   frame_err     - sticky, more than WIN_COUNT windows in this frame
// Optional build macro SAD_THRESHOLD_EN adds sad_threshold (in) and
// hit_count (out): number of windows with SAD below the threshold.
// Pipeline: S1 abs diffs, S2 row sums, S3 total, S4 compare/update.
// ----------------------------------------------------------------------------
module sad_matcher
  import astro_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  window_t          template_data,
  input  logic             template_load,
  input  logic             start,
  sad_matcher_if.slave     win,
  output logic             busy,
  output logic             result_valid,
  output logic [SAD_W-1:0] best_sad,
  output logic [6:0]       best_x,
  output logic [6:0]       best_y,
  output logic             frame_err
`ifdef SAD_THRESHOLD_EN
  ,
  input  logic [15:0]      sad_threshold,
  output logic [12:0]      hit_count
`endif
);

  localparam logic [1:0] IDLE  = ST_IDLE;
  localparam logic [1:0] RUN   = ST_RUN;
  localparam logic [1:0] DRAIN = ST_DRAIN;
  localparam logic [1:0] DONE  = ST_DONE;

  logic [1:0]       r_state, w_state_next;
  window_t          r_template;
  logic [6:0]       r_x, r_y, w_x_next, w_y_next;
  logic [12:0]      r_count;
  logic             r_frame_err;
  logic [2:0]       r_valid;          // [0]=S1, [1]=S2, [2]=S3 holds a window
  pos_t             r_pos1, r_pos2, r_pos3;
  logic [SAD_W-1:0] r_sad;
  logic [SAD_W-1:0] r_best_sad;
  logic [6:0]       r_best_x, r_best_y;
  logic             w_accept;
  logic [11:0]      w_row_sum [WIN_DIM];
  logic [SAD_W-1:0] w_total;
`ifdef SAD_THRESHOLD_EN
  logic [12:0]      r_hit_count;
`endif

  assign win.receive = (r_state == RUN) && win.window_ready;
  // A window arriving alongside start belongs to the frame being abandoned.
  assign w_accept    = win.receive && !start;

  for (genvar gi = 0; gi < WIN_DIM; gi++) begin : g_row
    sad_row_unit u_row (
      .clk        (clk),
      .i_tmpl_row (r_template[gi]),
      .i_win_row  (win.window_data[gi]),
      .o_row_sum  (w_row_sum[gi])
    );
  end

  // Max total is 256 x 255 = 65280, so 16 bits never overflow.
  always_comb begin
    w_total = '0;
    for (int i = 0; i < WIN_DIM; i++) begin
      w_total = w_total + SAD_W'(w_row_sum[i]);
    end
  end

  // Raster position: after (64,64) the next position is (0,0), which is
  // exactly where an over-length frame's extra window lands.
  always_comb begin
    w_x_next = r_x + 7'd1;
    w_y_next = r_y;
    if (r_x == 7'(POS_MAX)) begin
      w_x_next = '0;
      w_y_next = (r_y == 7'(POS_MAX)) ? 7'd0 : r_y + 7'd1;
    end
  end

  always_comb begin
    w_state_next = r_state;
    if (start) begin
      w_state_next = RUN;
    end else begin
      case (r_state)
        RUN:     if (win.frame_done) w_state_next = DRAIN;
        DRAIN:   if (r_valid == '0)  w_state_next = DONE;
        DONE:    w_state_next = IDLE;
        default: w_state_next = r_state;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_template  <= '0;
      r_x         <= '0;
      r_y         <= '0;
      r_count     <= '0;
      r_frame_err <= 1'b0;
      r_valid     <= '0;
      r_best_sad  <= '1;
      r_best_x    <= '0;
      r_best_y    <= '0;
`ifdef SAD_THRESHOLD_EN
      r_hit_count <= '0;
`endif
    end else begin
      r_state <= w_state_next;
      if (r_state == IDLE && template_load) begin
        r_template <= template_data;
      end
      if (start) begin
        r_x         <= '0;
        r_y         <= '0;
        r_count     <= '0;
        r_frame_err <= 1'b0;
        r_valid     <= '0;
        r_best_sad  <= '1;
        r_best_x    <= '0;
        r_best_y    <= '0;
`ifdef SAD_THRESHOLD_EN
        r_hit_count <= '0;
`endif
      end else begin
        r_valid <= {r_valid[1:0], w_accept};
        if (w_accept) begin
          r_x <= w_x_next;
          r_y <= w_y_next;
          // Count saturates at WIN_COUNT; any accept beyond it is an error.
          if (r_count == 13'(WIN_COUNT)) begin
            r_frame_err <= 1'b1;
          end else begin
            r_count <= r_count + 13'd1;
          end
        end
        // Strict compare keeps the earliest window on ties.
        if (r_valid[2] && (r_sad < r_best_sad)) begin
          r_best_sad <= r_sad;
          r_best_x   <= r_pos3.x;
          r_best_y   <= r_pos3.y;
        end
`ifdef SAD_THRESHOLD_EN
        if (r_valid[2] && (r_sad < sad_threshold)) begin
          r_hit_count <= r_hit_count + 13'd1;
        end
`endif
      end
    end
  end

  // Datapath registers follow the valid bits; their contents only matter
  // while the matching valid bit is set.
  always_ff @(posedge clk) begin
    r_pos1 <= '{x: r_x, y: r_y};
    r_pos2 <= r_pos1;
    r_pos3 <= r_pos2;
    r_sad  <= w_total;
  end

  assign busy         = (r_state != IDLE);
  assign result_valid = (r_state == DONE);
  assign best_sad     = r_best_sad;
  assign best_x       = r_best_x;
  assign best_y       = r_best_y;
  assign frame_err    = r_frame_err;
`ifdef SAD_THRESHOLD_EN
  assign hit_count    = r_hit_count;
`endif

endmodule

// File: doc/sad_matcher.md
SAD_MATCHER -- requirements
Module: sad_matcher

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset: clk  input  1  rising-edge clock; rst  input  1  synchronous active-high reset.
REQ-002 Ports SHALL be:
  template_data  input  16x16x8 (packed [15:0][15:0][7:0])  reference patch;
  template_load  input  1  capture template_data;
  start  input  1  begin new frame search;
  window_data  input  16x16x8 (packed [15:0][15:0][7:0])  candidate window from window handler;
  window_ready  input  1  window_data valid this cycle;
  frame_done  input  1  window handler finished frame;
  receive  output  1  window accepted this cycle;
  busy  output  1  state != IDLE;
  result_valid  output  1  one-cycle pulse, results final;
  best_sad  output  16  minimum SAD;
  best_x  output  7  window column of minimum, 0..64;
  best_y  output  7  window row of minimum, 0..64;
  frame_err  output  1  sticky, more than 4225 windows this frame.

Function
REQ-003 The block SHALL use FSM states IDLE, RUN, DRAIN, DONE.
REQ-004 IDLE: template_load=1 SHALL latch template_data into an internal register on that edge; template_load SHALL be ignored outside IDLE.
REQ-005 start=1 in any state SHALL, next cycle, enter RUN and:
  - set best_sad=16'hFFFF, best_x=0, best_y=0;
  - zero the position counters;
  - clear all pipeline valid bits and frame_err.
REQ-006 RUN: window_ready=1 SHALL assert receive combinationally in the same cycle and launch one window into the pipeline. Throughput is one window per cycle, with no backpressure.
REQ-007 window_ready outside RUN SHALL be ignored (receive=0).
REQ-008 Pipeline stages:
  - S1: 256 absolute differences, 8-bit.
  - S2: 16 row sums, 12-bit.
  - S3: total, 16-bit, no saturation; maximum is 65280.
  - S4: compare/update.
  Update latency from accept to best_* SHALL be 4 cycles.
REQ-009 Each accepted window SHALL carry the position (x,y) held at accept. Ordering is raster: x increments 0..64; at x=64, x wraps to 0 and y increments.
REQ-010 Update SHALL occur only if sad < best_sad (strict). Ties keep the earliest raster position.
REQ-011 A 4226th accept in one frame SHALL set frame_err. That window SHALL be processed with x,y wrapped to 0,0.
REQ-012 frame_done=1 in RUN SHALL go to DRAIN. A window accepted in the same cycle SHALL still be processed.
REQ-013 DRAIN SHALL stay until all pipeline valid bits are 0, then go to DONE.
REQ-014 DONE SHALL pulse result_valid for one cycle, then go to IDLE. best_* SHALL hold until the next start.
REQ-015 frame_done outside RUN SHALL be ignored.

Reset
REQ-016 rst SHALL force:
  - IDLE;
  - receive=0, result_valid=0, busy=0, frame_err=0;
  - best_sad=16'hFFFF, best_x=0, best_y=0;
  - pipeline valids=0, counters=0, template register=0.
REQ-017 rst mid-RUN SHALL discard in-flight windows. No result_valid SHALL follow.

Configuration
REQ-018 Macro SAD_THRESHOLD_EN defined SHALL add:
  - input sad_threshold[15:0];
  - output hit_count[12:0], which increments at S4 for each window with sad < sad_threshold, clears on start/rst, and holds after DONE.
REQ-019 Without SAD_THRESHOLD_EN, those ports and logic SHALL be absent. All other behaviour is identical.

Structure
REQ-020 Shared package astro_pkg SHALL hold:
  - constants WIN_DIM=16, POS_MAX=64, SAD_W=16, WIN_COUNT=4225;
  - typedef window_t ([15:0][15:0][7:0]);
  - the FSM state enum.
REQ-021 Sub-module sad_row_unit SHALL compute, for one 16-pixel row, the abs-diffs and registered 12-bit row sum. It is instantiated 16 times.

Verification
REQ-022 Template all 8'd10; window all 8'd10 at position (0,0); windows elsewhere 8'd20 -> best_sad=0, best_x=0, best_y=0, result_valid after DRAIN.
REQ-023 Template all 0; one window all 8'd255 at (37,12); all others 8'd1; frame_done after window 4225 -> best_sad=256, best_x=0, best_y=0. Tie rule: first window wins, and max SAD 65280 is never chosen.
REQ-024 Distinct minimum of SAD=5 injected at window index 4224 -> best_x=64, best_y=64.
REQ-025 frame_done coincident with a window_ready giving the minimum -> that window is reflected in best_*; result_valid occurs exactly 4 cycles after DRAIN entry.
REQ-026 rst asserted 2 cycles after a winning window accept -> best_sad=16'hFFFF, no result_valid. With SAD_THRESHOLD_EN, sad_threshold=100 and 3 windows below it -> hit_count=3.
